// File: rtl/washer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// washer_pkg : default plant durations and actuator/sensor bit ordering
// Revision   : 1.0
// ---------------------------------------------------------------------------
package washer_pkg;

  localparam int C_LEVEL_W      = 4;
  localparam int C_FILL_CYCLES  = 4;
  localparam int C_DRAIN_CYCLES = 4;
  localparam int C_DET_CYCLES   = 2;
  localparam int C_WASH_CYCLES  = 6;
  localparam int C_SPIN_CYCLES  = 5;

  // Field order is the bit order seen by automatic_washing_machine.
  typedef struct packed {
    logic door_lock;
    logic motor_on;
    logic fill_value_on;
    logic drain_value_on;
    logic water_wash;
    logic done;
  } act_t;

  typedef struct packed {
    logic door_close;
    logic filled;
    logic detergent_added;
    logic cycle_timeout;
    logic drained;
    logic spin_timeout;
    logic valve_conflict;
  } sens_t;

  localparam sens_t C_SENS_RESET = '{
    door_close:      1'b0,
    filled:          1'b0,
    detergent_added: 1'b0,
    cycle_timeout:   1'b0,
    drained:         1'b1,
    spin_timeout:    1'b0,
    valve_conflict:  1'b0
  };

  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/washer_plant_model_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// washer_plant_model_if : controller <-> drum plant actuator/sensor bundle
// Revision              : 1.0
// ---------------------------------------------------------------------------
interface washer_plant_model_if;
  import washer_pkg::*;

  logic  door_open_req;
  act_t  act;
  sens_t sens;

  modport master (
    output door_open_req,
    output act,
    input  sens
  );

  modport slave (
    input  door_open_req,
    input  act,
    output sens
  );

endinterface
`default_nettype wire

// File: rtl/washer_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// washer_timer : saturating up-counter, clear has priority over run
// Revision     : 1.0
// ---------------------------------------------------------------------------
module washer_timer #(
  parameter int W     = 3,
  parameter int LIMIT = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam logic [W-1:0] C_LIMIT = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != C_LIMIT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/washer_plant_model.sv
`default_nettype none
// ---------------------------------------------------------------------------
// washer_plant_model : drum plant/sensor model (level, dispenser, timers, door)
// Revision           : 1.0
// ---------------------------------------------------------------------------
module washer_plant_model
  import washer_pkg::*;
#(
  parameter int LEVEL_W      = C_LEVEL_W,
  parameter int FILL_CYCLES  = C_FILL_CYCLES,
  parameter int DRAIN_CYCLES = C_DRAIN_CYCLES,
  parameter int DET_CYCLES   = C_DET_CYCLES,
  parameter int WASH_CYCLES  = C_WASH_CYCLES,
  parameter int SPIN_CYCLES  = C_SPIN_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  washer_plant_model_if.slave  plant_io
);

  localparam logic [LEVEL_W-1:0] C_FULL = LEVEL_W'(FILL_CYCLES);
  // Drain step is FILL/DRAIN, but never zero so a slow drain still empties.
  localparam int C_DRAIN_STEP_I =
    (DRAIN_CYCLES > 0 && FILL_CYCLES > DRAIN_CYCLES) ? (FILL_CYCLES / DRAIN_CYCLES) : 1;
  localparam logic [LEVEL_W-1:0] C_DRAIN_STEP = LEVEL_W'(C_DRAIN_STEP_I);
  localparam int C_DET_W  = cnt_w(DET_CYCLES);
  localparam int C_WASH_W = cnt_w(WASH_CYCLES);
  localparam int C_SPIN_W = cnt_w(SPIN_CYCLES);

  act_t act;
  logic door_open_req;

  assign act           = plant_io.act;
  assign door_open_req = plant_io.door_open_req;

  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_d;
  logic               conflict_q;
  logic               conflict_d;
  logic               door_close_q;
  logic               door_close_d;

  always_comb begin
    level_d      = level_q;
    conflict_d   = conflict_q;
    door_close_d = door_close_q;

    if (act.fill_value_on && act.drain_value_on) begin
      conflict_d = 1'b1;
    end else if (act.fill_value_on) begin
      if (level_q < C_FULL) begin
        level_d = level_q + LEVEL_W'(1);
      end
    end else if (act.drain_value_on) begin
      level_d = (level_q > C_DRAIN_STEP) ? (level_q - C_DRAIN_STEP) : '0;
    end

    // While latched the sensor holds whatever it read when the lock engaged.
    if (!act.door_lock) begin
      door_close_d = ~door_open_req;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q      <= '0;
      conflict_q   <= 1'b0;
      door_close_q <= 1'b0;
    end else begin
      level_q      <= level_d;
      conflict_q   <= conflict_d;
      door_close_q <= door_close_d;
    end
  end

  logic filled;
  logic drained;
  logic motor_eff;
  logic det_done;
  logic wash_done;
  logic spin_done;

  assign filled    = (level_q == C_FULL);
  assign drained   = (level_q == '0);
  assign motor_eff = act.motor_on & door_close_q;

  washer_timer #(
    .W     (C_DET_W),
    .LIMIT (DET_CYCLES)
  ) u_det_timer (
    .clk       (clk),
    .reset     (reset),
    .run_i     (act.door_lock & filled & ~act.motor_on & ~act.water_wash),
    .clr_i     (drained | act.done),
    .expired_o (det_done)
  );

  washer_timer #(
    .W     (C_WASH_W),
    .LIMIT (WASH_CYCLES)
  ) u_wash_timer (
    .clk       (clk),
    .reset     (reset),
    .run_i     (motor_eff & ~act.drain_value_on),
    .clr_i     (~act.motor_on | act.drain_value_on),
    .expired_o (wash_done)
  );

  washer_timer #(
    .W     (C_SPIN_W),
    .LIMIT (SPIN_CYCLES)
  ) u_spin_timer (
    .clk       (clk),
    .reset     (reset),
    .run_i     (motor_eff & act.drain_value_on),
    .clr_i     (~act.motor_on),
    .expired_o (spin_done)
  );

  assign plant_io.sens = '{
    door_close:      door_close_q,
    filled:          filled,
    detergent_added: det_done,
    cycle_timeout:   wash_done,
    drained:         drained,
    spin_timeout:    spin_done,
    valve_conflict:  conflict_q
  };

endmodule
`default_nettype wire

// File: tb/tb_washer_plant_model.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_washer_plant_model : scoreboard bench with a cycle-level reference model
// Revision              : 1.0
// ---------------------------------------------------------------------------
module tb_washer_plant_model;
  import washer_pkg::*;

  localparam int FILL  = C_FILL_CYCLES;
  localparam int DRAIN = C_DRAIN_CYCLES;
  localparam int DET   = C_DET_CYCLES;
  localparam int WASH  = C_WASH_CYCLES;
  localparam int SPIN  = C_SPIN_CYCLES;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  washer_plant_model_if plant ();

  washer_plant_model #(
    .LEVEL_W      (C_LEVEL_W),
    .FILL_CYCLES  (FILL),
    .DRAIN_CYCLES (DRAIN),
    .DET_CYCLES   (DET),
    .WASH_CYCLES  (WASH),
    .SPIN_CYCLES  (SPIN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .plant_io (plant.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    if (FILL < 1 || FILL > (2 ** C_LEVEL_W) - 1) begin
      $display("FAIL param_range FILL_CYCLES=%0d", FILL);
      $fatal(1);
    end
  end

  // Reference model: plain quantities, one update per clock.
  int    m_level, m_det, m_wash, m_spin;
  bit    m_door, m_conf;
  sens_t exp_q[$];

  function automatic sens_t model_out();
    sens_t s;
    s.door_close      = m_door;
    s.filled          = (m_level == FILL);
    s.detergent_added = (m_det == DET);
    s.cycle_timeout   = (m_wash == WASH);
    s.drained         = (m_level == 0);
    s.spin_timeout    = (m_spin == SPIN);
    s.valve_conflict  = m_conf;
    return s;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_level = 0; m_det = 0; m_wash = 0; m_spin = 0;
      m_door  = 1'b0; m_conf = 1'b0;
      exp_q.delete();
    end else begin
      act_t a;
      bit   was_full, was_empty, spinning_drum;
      a             = plant.act;
      was_full      = (m_level == FILL);
      was_empty     = (m_level == 0);
      spinning_drum = a.motor_on && m_door;

      if (a.fill_value_on && a.drain_value_on) m_conf = 1'b1;
      else if (a.fill_value_on)  m_level = (m_level + 1 > FILL) ? FILL : m_level + 1;
      else if (a.drain_value_on) m_level = (m_level - 1 < 0) ? 0 : m_level - 1;

      if (was_empty || a.done) m_det = 0;
      else if (a.door_lock && was_full && !a.motor_on && !a.water_wash && m_det < DET) m_det++;

      if (!a.motor_on || a.drain_value_on) m_wash = 0;
      else if (spinning_drum && m_wash < WASH) m_wash++;

      if (!a.motor_on) m_spin = 0;
      else if (spinning_drum && a.drain_value_on && m_spin < SPIN) m_spin++;

      if (!a.door_lock) m_door = !plant.door_open_req;

      exp_q.push_back(model_out());
    end
  end

  always @(posedge clk) begin
    sens_t e;
    #1;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (plant.sens !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t got=%b expected=%b", $time, plant.sens, e);
      end
    end
  end

  task automatic drive(input bit open, input bit lock, input bit motor, input bit fill,
                       input bit drain, input bit ww, input bit dn);
    @(negedge clk);
    plant.door_open_req = open;
    plant.act = '{door_lock: lock, motor_on: motor, fill_value_on: fill,
                  drain_value_on: drain, water_wash: ww, done: dn};
    @(posedge clk);
    #2;
  endtask

  task automatic spot(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b expected=%b t=%0t", name, got, want, $time);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (plant.sens !== C_SENS_RESET) begin
      failures++;
      $display("FAIL %s got=%b expected=%b t=%0t", name, plant.sens, C_SENS_RESET, $time);
    end
  endtask

  task automatic async_reset();
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset_values");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    plant.door_open_req = 1'b0;
    plant.act = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset_values");
    @(negedge clk);
    reset = 1'b0;

    drive(0, 0, 0, 0, 0, 0, 0);
    spot("idle_door_close", plant.sens.door_close, 1'b1);
    spot("idle_drained", plant.sens.drained, 1'b1);

    repeat (3) drive(0, 0, 0, 1, 0, 0, 0);
    spot("fill3_not_full", plant.sens.filled, 1'b0);
    drive(0, 0, 0, 1, 0, 0, 0);
    spot("fill4_full", plant.sens.filled, 1'b1);
    drive(0, 0, 0, 0, 1, 0, 0);
    spot("drain1_not_full", plant.sens.filled, 1'b0);
    repeat (2) drive(0, 0, 0, 0, 1, 0, 0);
    spot("drain3_not_empty", plant.sens.drained, 1'b0);
    drive(0, 0, 0, 0, 1, 0, 0);
    spot("drain4_empty", plant.sens.drained, 1'b1);

    repeat (4) drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    spot("det1_pending", plant.sens.detergent_added, 1'b0);
    drive(0, 1, 0, 0, 0, 0, 0);
    spot("det2_added", plant.sens.detergent_added, 1'b1);
    repeat (5) drive(0, 1, 1, 0, 0, 0, 0);
    spot("wash5_running", plant.sens.cycle_timeout, 1'b0);
    drive(0, 1, 1, 0, 0, 0, 0);
    spot("wash6_timeout", plant.sens.cycle_timeout, 1'b1);

    repeat (4) drive(0, 1, 1, 0, 1, 0, 0);
    spot("spin4_running", plant.sens.spin_timeout, 1'b0);
    drive(0, 1, 1, 0, 1, 0, 0);
    spot("spin5_timeout", plant.sens.spin_timeout, 1'b1);
    drive(0, 1, 0, 0, 0, 0, 0);
    spot("spin_motor_off", plant.sens.spin_timeout, 1'b0);

    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0);
    spot("conflict_set", plant.sens.valve_conflict, 1'b1);
    spot("conflict_level_held", plant.sens.drained, 1'b0);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
    spot("conflict_sticky", plant.sens.valve_conflict, 1'b1);

    async_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    spot("locked_ignores_open", plant.sens.door_close, 1'b1);
    repeat (3) drive(0, 1, 1, 0, 0, 0, 0);
    async_reset();

    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0);
    spot("locked_while_open", plant.sens.door_close, 1'b0);
    repeat (WASH + 1) drive(0, 1, 1, 0, 0, 0, 0);
    spot("interlock_no_wash", plant.sens.cycle_timeout, 1'b0);

    for (int i = 0; i < 800; i++) begin
      int v;
      v = $urandom_range(0, 39);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            (v < 14) || (v == 39), (v >= 14 && v < 28) || (v == 39),
            $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 59) == 0) async_reset();
    end

    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
